vedic_mult_pipe: RTL and testbench
==================================

// Module: vedic_mult_pipe
// PURPOSE
//  Pipelined, parametrised Urdhva-Tiryagbhyam (Vedic) multiplier with valid/ready handshakes.
//  It computes A*B for WIDTH-bit operands, with signed or unsigned mode selected per transaction.
//  The datapath splits each operand into halves and forms four sub-products; a registered adder tree combines them.
//  Sits between operand producers and result consumers as the streaming successor to the fixed 8-bit ebm multiplier.
// PARAMETERS
//  WIDTH     8   operand width; power of two, 4..32; product is 2*WIDTH bits
//  TAG_W     4   width of a user tag carried alongside each operand pair, returned with its result
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset; released synchronously by the system
//  in_valid   in   1         operand pair presented
//  in_ready   out  1         block accepts operands this cycle
//  in_a       in   WIDTH     multiplicand
//  in_b       in   WIDTH     multiplier
//  in_signed  in   1         1: two's-complement operands; 0: unsigned
//  in_tag     in   TAG_W     user tag
//  out_valid  out  1         result presented
//  out_ready  in   1         consumer accepts result this cycle
//  out_p      out  2*WIDTH   product
//  out_tag    out  TAG_W     tag of this result
//  inflight   out  2         number of occupied stages, 0..3
// BEHAVIOUR
//  Reset: all stage valid bits clear; out_valid=0, out_p=0, out_tag=0, inflight=0; in_ready=1 once reset is released.
//  Stages: S1 register (magnitudes, sign flag, tag); S2 register (four WIDTH-bit half sub-products); S3 output register.
//  S1 magnitude: when in_signed=1 and the MSB is set, the operand is negated. -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
//  S1 sign flag: neg = in_signed & (a[MSB]^b[MSB]).
//  S2: HH, HL, LH, LL = WIDTH/2 x WIDTH/2 unsigned products of the magnitudes.
//  S3: P = (HH<<WIDTH) + ((HL+LH)<<WIDTH/2) + LL.
//  S3 result: out_p = neg ? -P : P. All arithmetic is performed at 2*WIDTH bits; no overflow is possible.
//  Stage transfer: stage k loads when stage k-1 holds valid data AND (stage k is empty OR stage k is unloading this cycle).
//  Input handshake: a transfer occurs on in_valid & in_ready. in_ready = ~S1.v | S1 advancing. in_ready is combinational from out_ready; it must not depend on in_valid.
//  Output handshake: a transfer occurs on out_valid & out_ready.
//  Output stability: while out_valid=1 & out_ready=0, out_p and out_tag hold stable and all stages stall.
//  Latency: 3 cycles from the accept edge to out_valid, with out_ready held at 1.
//  Throughput: 1 result per cycle sustained with no bubbles.
//  Full pipeline: all three stages valid and out_ready=0 gives in_ready=0 and inflight=3.
//  Simultaneous accept and emit when full: with out_ready=1 and in_valid=1, all stages advance and a new pair is accepted in the same cycle. inflight stays 3.
//  Empty pipeline: out_valid=0; out_p holds its last value (it is not cleared).
//  inflight updates every cycle as the count of valid stages.
//  Reset mid-operation: all in-flight transactions are discarded. No result is ever emitted for operands accepted before reset.
//  Ordering: results emerge in acceptance order; out_tag always matches the tag accepted with the operands.
//  Input sampling: in_a, in_b, in_signed and in_tag are sampled only on the accept edge.
// TESTING
//  1 WIDTH=8 unsigned 8'hFF*8'hFF, tag 3 -> out_p=16'hFE01, out_tag=3, out_valid 3 cycles after accept.
//  2 Signed corners:
//     -1*-1 -> 16'h0001
//     -128*-128 -> 16'h4000
//     -128*127 -> 16'hC080
//     0*-5 -> 16'h0000
//     unsigned 8'h80*8'h80 -> 16'h4000
//  3 Back-to-back: 100 random pairs with out_ready=1 -> 100 results in order, one per cycle, in_ready never low.
//  4 Backpressure: out_ready=0 for 10 cycles while streaming ->
//     in_ready falls after 3 accepts; inflight=3; out_p stable;
//     on release, no loss or duplication of results.
//  5 Reset mid-stream: assert rst_n=0 with 3 in flight ->
//     out_valid=0 and inflight=0 immediately;
//     no stale result after release; first new result correct.
//  6 Exhaustive WIDTH=4 sweep, both modes and random out_ready -> every product matches the reference model.

Source files
------------

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: magnitude, half-product and
// combine stages, with a valid/ready stream on each side.
module vedic_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         inflight
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    logic s1_v, s2_v, s3_v;
    logic load1, load2, load3;

    logic [WIDTH-1:0] s1_ma, s1_mb;
    logic             s1_neg;
    logic [TAG_W-1:0] s1_tag;

    logic [WIDTH-1:0] s2_hh, s2_hl, s2_lh, s2_ll;
    logic             s2_neg;
    logic [TAG_W-1:0] s2_tag;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] pp_hh, pp_hl, pp_lh, pp_ll;
    logic [PW-1:0]    sum_p;

    assign load3     = s2_v & (~s3_v | out_ready);
    assign load2     = s1_v & (~s2_v | load3);
    assign in_ready  = ~s1_v | load2;
    assign load1     = in_valid & in_ready;
    assign out_valid = s3_v;
    assign inflight  = {1'b0, s1_v} + {1'b0, s2_v} + {1'b0, s3_v};

    // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned
    always_comb begin
        mag_a = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;
    end

    always_comb begin
        pp_hh = WIDTH'(s1_ma[WIDTH-1:H]) * WIDTH'(s1_mb[WIDTH-1:H]);
        pp_hl = WIDTH'(s1_ma[WIDTH-1:H]) * WIDTH'(s1_mb[H-1:0]);
        pp_lh = WIDTH'(s1_ma[H-1:0])     * WIDTH'(s1_mb[WIDTH-1:H]);
        pp_ll = WIDTH'(s1_ma[H-1:0])     * WIDTH'(s1_mb[H-1:0]);
    end

    always_comb begin
        sum_p = (PW'(s2_hh) << WIDTH)
              + ((PW'(s2_hl) + PW'(s2_lh)) << H)
              + PW'(s2_ll);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= load1 | (s1_v & ~load2);
            s2_v <= load2 | (s2_v & ~load3);
            s3_v <= load3 | (s3_v & ~out_ready);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ma  <= '0;
            s1_mb  <= '0;
            s1_neg <= 1'b0;
            s1_tag <= '0;
        end else if (load1) begin
            s1_ma  <= mag_a;
            s1_mb  <= mag_b;
            s1_neg <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            s1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_hh  <= '0;
            s2_hl  <= '0;
            s2_lh  <= '0;
            s2_ll  <= '0;
            s2_neg <= 1'b0;
            s2_tag <= '0;
        end else if (load2) begin
            s2_hh  <= pp_hh;
            s2_hl  <= pp_hl;
            s2_lh  <= pp_lh;
            s2_ll  <= pp_ll;
            s2_neg <= s1_neg;
            s2_tag <= s1_tag;
        end
    end

    // out_p is left untouched when the pipe drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p   <= '0;
            out_tag <= '0;
        end else if (load3) begin
            out_p   <= s2_neg ? -sum_p : sum_p;
            out_tag <= s2_tag;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: directed corners, random streams with
// backpressure and reset, and an exhaustive 4-bit sweep.
module tb_vedic_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_p;
    logic [1:0]  inflight;

    logic        n_in_valid, n_in_ready, n_in_signed;
    logic        n_out_valid, n_out_ready;
    logic [3:0]  n_in_a, n_in_b, n_in_tag, n_out_tag;
    logic [7:0]  n_out_p;
    logic [1:0]  n_inflight;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  tag;
    } exp_t;
    exp_t q[$];

    vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag),
        .inflight(inflight)
    );

    vedic_mult_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_a(n_in_a), .in_b(n_in_b),
        .in_signed(n_in_signed), .in_tag(n_in_tag),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_p(n_out_p), .out_tag(n_out_tag),
        .inflight(n_inflight)
    );

    function automatic logic [15:0] ref8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic s);
        int x, y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 8'(x * y);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0;
        out_ready = 1;
        n_in_valid = 0; n_in_a = 0; n_in_b = 0; n_in_signed = 0;
        n_in_tag = 0; n_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || inflight !== 2'd0) begin
            errors++;
            $display("FAIL reset_valid: out_valid=%b inflight=%0d want 0 0",
                     out_valid, inflight);
        end
        checks++;
        if (out_p !== 16'h0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: out_p=%h out_tag=%h want 0 0",
                     out_p, out_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b/%b want 1",
                     in_ready, n_in_ready);
        end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        in_valid = 1; in_a = 8'hFF; in_b = 8'hFF;
        in_signed = 0; in_tag = 4'd3; out_ready = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_accept: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_p !== 16'hFE01 || out_tag !== 4'd3)
        begin
            errors++;
            $display("FAIL lat_result: v=%b p=%h tag=%0d want 1 fe01 3",
                     out_valid, out_p, out_tag);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || inflight !== 2'd0 || out_p !== 16'hFE01)
        begin
            errors++;
            $display("FAIL lat_drain: v=%b infl=%0d p=%h want 0 0 fe01",
                     out_valid, inflight, out_p);
        end
    endtask

    task automatic test_signed_corners();
        logic [7:0]  ca [5];
        logic [7:0]  cb [5];
        logic        cs [5];
        logic [15:0] cp [5];
        exp_t e;
        int sent = 0;
        int cyc = 0;
        ca = '{8'hFF, 8'h80, 8'h80, 8'h00, 8'h80};
        cb = '{8'hFF, 8'h80, 8'h7F, 8'hFB, 8'h80};
        cs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        cp = '{16'h0001, 16'h4000, 16'hC080, 16'h0000, 16'h4000};
        q.delete();
        while ((sent < 5 || q.size() != 0) && cyc < 100) begin
            @(posedge clk); #1;
            out_ready = 1;
            in_valid = (sent < 5);
            if (sent < 5) begin
                in_a = ca[sent]; in_b = cb[sent];
                in_signed = cs[sent]; in_tag = 4'(sent + 8);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back('{cp[sent], 4'(sent + 8)});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL corner_extra: p=%h", out_p);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL corner: p=%h tag=%0d want %h %0d",
                                 out_p, out_tag, e.p, e.tag);
                    end
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL corner_timeout: sent=%0d left=%0d want 5 0",
                     sent, q.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        int stalls = 0;
        q.delete();
        while ((sent < 100 || q.size() != 0) && cyc < 400) begin
            @(posedge clk); #1;
            out_ready = 1;
            in_valid = (sent < 100);
            if (sent < 100) begin
                in_a = 8'($urandom); in_b = 8'($urandom);
                in_signed = 1'($urandom); in_tag = 4'(sent);
            end
            @(negedge clk);
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                q.push_back('{ref8(in_a, in_b, in_signed), in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: p=%h", out_p);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL b2b: p=%h tag=%0d want %h %0d",
                                 out_p, out_tag, e.p, e.tag);
                    end
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (got != 100 || cyc >= 400) begin
            errors++;
            $display("FAIL b2b_count: got=%0d want 100", got);
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL b2b_ready: low cycles=%0d want 0", stalls);
        end
        checks++;
        if (last - first != 99) begin
            errors++;
            $display("FAIL b2b_rate: span=%0d want 99", last - first);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stall_acc = 0;
        q.delete();
        while ((sent < 20 || q.size() != 0) && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 10);
            in_valid = (sent < 20);
            if (sent < 20) begin
                in_a = 8'($urandom); in_b = 8'($urandom);
                in_signed = 1'($urandom); in_tag = 4'(sent);
            end
            @(negedge clk);
            if (cyc >= 3 && cyc < 10) begin
                checks++;
                if (in_ready !== 1'b0 || inflight !== 2'd3) begin
                    errors++;
                    $display("FAIL bp_full: in_ready=%b infl=%0d want 0 3",
                             in_ready, inflight);
                end
                checks++;
                if (q.size() == 0 || out_valid !== 1'b1
                    || out_p !== q[0].p || out_tag !== q[0].tag) begin
                    errors++;
                    $display("FAIL bp_hold: v=%b p=%h tag=%0d",
                             out_valid, out_p, out_tag);
                end
            end
            if (in_valid && in_ready) begin
                if (cyc < 10) stall_acc++;
                q.push_back('{ref8(in_a, in_b, in_signed), in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: p=%h", out_p);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL bp: p=%h tag=%0d want %h %0d",
                                 out_p, out_tag, e.p, e.tag);
                    end
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 1;
        checks++;
        if (stall_acc != 3) begin
            errors++;
            $display("FAIL bp_accepts: got=%0d want 3", stall_acc);
        end
        checks++;
        if (got != 20 || cyc >= 200) begin
            errors++;
            $display("FAIL bp_count: got=%0d want 20", got);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1; in_a = 8'($urandom); in_b = 8'($urandom);
            in_signed = 1'($urandom); in_tag = 4'(i);
        end
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        checks++;
        if (inflight !== 2'd3) begin
            errors++;
            $display("FAIL rst_fill: inflight=%0d want 3", inflight);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || inflight !== 2'd0 || out_p !== 16'h0)
        begin
            errors++;
            $display("FAIL rst_async: v=%b infl=%0d p=%h want 0 0 0",
                     out_valid, inflight, out_p);
        end
        @(posedge clk); #1;
        rst_n = 1;
        q.delete();
        while ((sent < 1 || q.size() != 0) && cyc < 50) begin
            @(posedge clk); #1;
            out_ready = 1;
            in_valid = (sent < 1);
            if (sent < 1) begin
                in_a = 8'h9C; in_b = 8'h37; in_signed = 1;
                in_tag = 4'hA;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back('{ref8(in_a, in_b, in_signed), in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rst_stale: p=%h tag=%0d", out_p, out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_p !== e.p || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL rst_first: p=%h tag=%0d want %h %0d",
                                 out_p, out_tag, e.p, e.tag);
                    end
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        checks++;
        if (got != 1 || cyc >= 50) begin
            errors++;
            $display("FAIL rst_count: results=%0d want 1", got);
        end
    endtask

    task automatic test_sweep4();
        logic [7:0] ep [$];
        logic [3:0] et [$];
        logic [7:0] wp;
        logic [3:0] wt;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while ((sent < 512 || ep.size() != 0) && cyc < 6000) begin
            @(posedge clk); #1;
            n_out_ready = 1'($urandom);
            n_in_valid = (sent < 512);
            if (sent < 512) begin
                n_in_a = 4'(sent); n_in_b = 4'(sent >> 4);
                n_in_signed = 1'(sent >> 8); n_in_tag = 4'(sent * 7);
            end
            @(negedge clk);
            if (n_in_valid && n_in_ready) begin
                ep.push_back(ref4(n_in_a, n_in_b, n_in_signed));
                et.push_back(n_in_tag);
                sent++;
            end
            if (n_out_valid && n_out_ready) begin
                got++;
                checks++;
                if (ep.size() == 0) begin
                    errors++;
                    $display("FAIL w4_extra: p=%h", n_out_p);
                end else begin
                    wp = ep.pop_front();
                    wt = et.pop_front();
                    if (n_out_p !== wp || n_out_tag !== wt) begin
                        errors++;
                        $display("FAIL w4: p=%h tag=%0d want %h %0d",
                                 n_out_p, n_out_tag, wp, wt);
                    end
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        n_in_valid = 0; n_out_ready = 1;
        checks++;
        if (got != 512 || cyc >= 6000) begin
            errors++;
            $display("FAIL w4_count: got=%0d want 512", got);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_signed_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_sweep4();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
